// File: rtl/control_pkg.sv
// control_pkg: shared state, opcode, ALU and mux-select encodings for the multicycle controller.
package control_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR = 4'b0011, ALU_SLT = 4'b0101;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
    localparam logic ADR_PC = 1'b0, ADR_RESULT = 1'b1;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011;

    function automatic logic [2:0] imm_fmt(input logic [6:0] op);
        return op == OP_SW ? IMM_S : op == OP_BR ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_R:         return S_EXEC_R;
            OP_I:         return S_EXEC_I;
            OP_BR:        return S_BRANCH;
            OP_JAL:       return S_JAL;
            default:      return S_TRAP;
        endcase
    endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction fields and flags in, datapath controls out.
interface control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, eq, mem_ready;
    logic [3:0] aluctrl;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       adr_src;
    logic [2:0] imm_src;
    logic       ir_write, pc_write, mem_write, reg_write, illegal;
    modport master (
        output op, funct3, funct7b5, eq, mem_ready,
        input  aluctrl, alu_src_a, alu_src_b, result_src, adr_src, imm_src,
               ir_write, pc_write, mem_write, reg_write, illegal
    );
    modport slave (
        input  op, funct3, funct7b5, eq, mem_ready,
        output aluctrl, alu_src_a, alu_src_b, result_src, adr_src, imm_src,
               ir_write, pc_write, mem_write, reg_write, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU operation and flags combinations we do not implement.
module alu_decoder
    import control_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] aluctrl_o,
    output logic       unsupported_o
);
    always_comb begin
        unsupported_o = 1'b0;
        case (funct3_i)
            3'b000:  aluctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
            3'b111:  aluctrl_o = ALU_AND;
            3'b110:  aluctrl_o = ALU_OR;
            3'b010:  aluctrl_o = ALU_SLT;
            default: begin
                aluctrl_o     = ALU_ADD;
                unsupported_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle RISC-V subset controller; Moore outputs, with FETCH/BRANCH strobes gated by mem_ready/eq.
module control_fsm
    import control_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    control_fsm_if.slave bus
);
    state_t     state_q, state_d;
    logic [3:0] dec_ctrl;
    logic       dec_bad;

    // funct7b5 selects subtract only for register-register ops; immediates have no subi
    alu_decoder u_alu_decoder (
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5 && (state_q == S_EXEC_R)),
        .aluctrl_o     (dec_ctrl),
        .unsupported_o (dec_bad)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:            state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:           state_d = decode_next(bus.op);
            S_MEMADR:           state_d = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:          state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:         state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB, S_ALUWB:   state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I: state_d = dec_bad ? S_TRAP : S_ALUWB;
            S_BRANCH:           state_d = bus.funct3[2:1] == 2'b00 ? S_FETCH : S_TRAP;
            S_JAL:              state_d = S_ALUWB;
            default:            state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q <= rst ? S_FETCH : state_d;
    end

    always_comb begin
        bus.aluctrl    = ALU_ADD;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.result_src = RES_ALUOUT;
        bus.adr_src    = ADR_PC;
        bus.imm_src    = IMM_I;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                bus.imm_src   = imm_fmt(bus.op);
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: bus.adr_src = ADR_RESULT;
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = ADR_RESULT;
                bus.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = SRCA_RS1;
                bus.aluctrl   = dec_ctrl;
            end
            S_EXEC_I: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.aluctrl   = dec_ctrl;
            end
            S_ALUWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                bus.aluctrl   = ALU_SUB;
                bus.pc_write  = bus.funct3 == 3'b000 ? bus.eq : bus.funct3 == 3'b001 ? !bus.eq : 1'b0;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_write  = 1'b1;
            end
            S_TRAP: bus.illegal = 1'b1;
            default: ;
        endcase
        // reset aborts the current instruction: nothing may be committed in the reset cycle
        if (rst) begin
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.illegal   = 1'b0;
        end
    end
endmodule
